// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the serial adder arbiter: FSM encoding, default width,
// port indices and the round-robin pick rule.
package serial_add_arbiter_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PORT_PC = 1'b0;
  localparam logic PORT_BR = 1'b1;

  // A lone requester wins; on a tie the port that was not served last wins.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
    logic p;
    if (r0 && r1) begin
      p = ~last;
    end else begin
      p = r1;
    end
    return p;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by both requesters.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  assign sum      = x ^ y ^ carryin;
  assign carryout = (x & y) | (x & carryin) | (y & carryin);

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-port round-robin arbiter feeding a single bit-serial adder, LSB first,
// one bit per cycle, with a registered result and per-port completion pulse.
module serial_add_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             busy,
  output logic             gnt,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             pick_s;
  logic             fa_sum_s;
  logic             fa_cout_s;

  full_adder u_fa (
    .x        (sa_q[0]),
    .y        (sb_q[0]),
    .carryin  (c_q),
    .sum      (fa_sum_s),
    .carryout (fa_cout_s)
  );

  assign pick_s = pick_port(req0, req1, last_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sa_d     = pick_s ? a1 : a0;
          sb_d     = pick_s ? b1 : b0;
          c_d      = pick_s ? cin1 : cin0;
          gnt_d    = pick_s;
          last_d   = pick_s;
          cnt_d    = '0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        result_d = {fa_sum_s, result_q[WIDTH-1:1]};
        c_d      = fa_cout_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        cout_d  = c_q;
        done0_d = (gnt_q == PORT_PC);
        done1_d = (gnt_q == PORT_BR);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign busy   = busy_q;
  assign gnt    = gnt_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-level model.
module tb_serial_add_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic         cin [2];
  logic         busy, gnt, done0, done1, cout;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_pass = 0;
  bit rnd_en = 1'b0;

  // transaction-level model state
  bit         m_busy, m_port, m_last, m_cout;
  bit [1:0]   m_done;
  int         m_t;
  bit [W:0]   m_sum;
  bit [W-1:0] m_result;
  int         n_ops = 0;

  serial_add_arbiter #(.WIDTH(W), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .a0(a[0]), .b0(b[0]), .cin0(cin[0]),
    .req1(req[1]), .a1(a[1]), .b1(b[1]), .cin1(cin[1]),
    .busy(busy), .gnt(gnt), .done0(done0), .done1(done1),
    .result(result), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: a grant starts a WIDTH+1 edge countdown to the completion pulse.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_t = 0;
      m_result = '0; m_cout = 1'b0; m_done = 2'b00;
    end else begin
      m_done = 2'b00;
      if (m_busy) begin
        m_t--;
        if (m_t == 0) begin
          m_busy = 1'b0;
          m_done[m_port] = 1'b1;
          m_result = m_sum[W-1:0];
          m_cout = m_sum[W];
          n_ops++;
        end
      end else if (req != 2'b00) begin
        m_port = (req == 2'b11) ? ~m_last : req[1];
        m_last = m_port;
        m_sum = {1'b0, a[m_port]} + {1'b0, b[m_port]} + {{W{1'b0}}, cin[m_port]};
        m_busy = 1'b1;
        m_t = W + 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("gnt", 32'(gnt), 32'(m_port));
      chk("done0", 32'(done0), 32'(m_done[0]));
      chk("done1", 32'(done1), 32'(m_done[1]));
      if (!m_busy) begin
        chk("result", 32'(result), 32'(m_result));
        chk("cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  // Random requesters: raise, drop when done or (rarely) before grant, jiggle operands.
  always @(negedge clk) begin
    if (rnd_en) begin
      for (int p = 0; p < 2; p++) begin
        if (req[p] && ((p == 0) ? done0 : done1)) begin
          req[p] = 1'b0;
        end else if (!req[p]) begin
          if ($urandom_range(3) == 0) begin
            req[p] = 1'b1;
            a[p] = W'($urandom); b[p] = W'($urandom); cin[p] = 1'($urandom);
          end
        end else begin
          if (!(m_busy && m_port == 1'(p)) && $urandom_range(15) == 0) req[p] = 1'b0;
          if ($urandom_range(3) == 0) a[p] = W'($urandom);
        end
      end
    end
  end

  task automatic do_op(input int p, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic [W-1:0] er, input logic ec);
    int cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    a[p] = av; b[p] = bv; cin[p] = cv; req[p] = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = (p == 0) ? done0 : done1;
    end
    chk("latency", 32'(cyc), 32'(W + 2));
    chk("op_result", 32'(result), 32'(er));
    chk("op_cout", 32'(cout), 32'(ec));
    chk("op_gnt", 32'(gnt), 32'(p));
    chk("model_result", 32'(m_result), 32'(er));
    req[p] = 1'b0;
  endtask

  initial begin
    int order [4];
    int nd;
    int cyc;
    for (int p = 0; p < 2; p++) begin a[p] = '0; b[p] = '0; cin[p] = 1'b0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);

    do_op(0, 8'h05, 8'h01, 1'b0, 8'h06, 1'b0);
    do_op(1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    do_op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // both held from reset: grants alternate starting with port 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a[0] = 8'h01; b[0] = 8'h02; cin[0] = 1'b0;
    a[1] = 8'h10; b[1] = 8'h20; cin[1] = 1'b1;
    req = 2'b11;
    nd = 0; cyc = 0;
    while (nd < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done0 || done1) begin
        order[nd] = done1 ? 1 : 0;
        chk("alt_result", 32'(result), done1 ? 32'h31 : 32'h03);
        nd++;
      end
    end
    req = 2'b00;
    chk("alt_count", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) chk("alt_order", 32'(order[i]), 32'(i % 2));

    // operand change mid-run is ignored
    @(negedge clk);
    a[0] = 8'h10; b[0] = 8'h20; cin[0] = 1'b0; req[0] = 1'b1;
    repeat (4) @(negedge clk);
    a[0] = 8'hAA;
    cyc = 0;
    while (!done0 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("stable_result", 32'(result), 32'h30);
    req[0] = 1'b0;

    // reset in the middle of a run aborts immediately
    @(negedge clk);
    a[0] = 8'h77; b[0] = 8'h11; req[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1; req[0] = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'({done1, done0}), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // randomized traffic on both ports
    n_ops = 0;
    rnd_en = 1'b1;
    repeat (3000) @(negedge clk);
    rnd_en = 1'b0;
    cyc = 0;
    while ((req != 2'b00 || busy) && cyc < 100) begin
      for (int p = 0; p < 2; p++) begin
        if (req[p] && (((p == 0) ? done0 : done1) || !(m_busy && m_port == 1'(p)))) req[p] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain", 32'(cyc < 100), 32'd1);
    chk("random_ops", 32'(n_ops > 50), 32'd1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
